// File: rtl/seg7_pkg.sv
// Segment encodings and BCD-to-7-segment lookup for the scan driver.
// Bit order is {a,b,c,d,e,f,g,dp}. All outputs are active high.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'b1111_1100;
  localparam logic [7:0] SEG_1     = 8'b0110_0000;
  localparam logic [7:0] SEG_2     = 8'b1101_1010;
  localparam logic [7:0] SEG_3     = 8'b1111_0010;
  localparam logic [7:0] SEG_4     = 8'b0110_0110;
  localparam logic [7:0] SEG_5     = 8'b1011_0110;
  localparam logic [7:0] SEG_6     = 8'b1011_1110;
  localparam logic [7:0] SEG_7     = 8'b1110_0000;
  localparam logic [7:0] SEG_8     = 8'b1111_1110;
  localparam logic [7:0] SEG_9     = 8'b1111_0110;
  localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

  // Non-BCD codes 10..15 are shown as a dark digit.
  function automatic logic [7:0] seg7_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: BCD digit plus blank and decimal-point controls.
// A blanked digit still lights its decimal point when dp is set.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] segments
);

  logic [7:0] glyph;

  always_comb begin
    glyph    = blank ? SEG_BLANK : seg7_encode(digit);
    segments = {glyph[7:1], dp};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with tear-free frame buffer,
// anti-ghost blanking, leading-zero suppression and per-digit blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load,
  input  logic                  decode_en,
  input  logic                  lz_suppress,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [7:0]            segments,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         frame_cnt;
  logic                  blink_phase;
  logic [4*N_DIGITS-1:0] pending_digits, shadow_digits;
  logic [N_DIGITS-1:0]   pending_dp, shadow_dp;

  logic                  slot_wrap, idx_last, frame_end;
  logic [N_DIGITS-1:0]   lz_blank, sel_onehot;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic                  blink_off, cur_blank, cur_dp;
  logic [7:0]            dec_seg;

  assign slot_wrap = (presc == PW'(SCAN_DIV - 1));
  assign idx_last  = (idx == IW'(N_DIGITS - 1));
  assign frame_end = slot_wrap && idx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      presc <= slot_wrap ? '0 : presc + PW'(1);
      if (slot_wrap)
        idx <= idx_last ? '0 : idx + IW'(1);
      if (frame_end) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // A load on the boundary cycle bypasses pending so it is not lost for a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_digits <= '0;
      pending_dp     <= '0;
      shadow_digits  <= '0;
      shadow_dp      <= '0;
    end else begin
      if (load) begin
        pending_digits <= digits_i;
        pending_dp     <= dp_i;
      end
      if (frame_end) begin
        shadow_digits <= load ? digits_i : pending_digits;
        shadow_dp     <= load ? dp_i     : pending_dp;
      end
    end
  end

  // Walk down from the most significant digit while every digit seen is zero.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int unsigned k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run && (shadow_digits[4*k +: 4] == 4'd0);
      lz_blank[k] = lz_suppress && zero_run;
    end
  end

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[idx] = 1'b1;
    cur_digit       = shadow_digits[{idx, 2'b00} +: 4];
    blink_off       = blink_mask[idx] && blink_phase;
    cur_blank       = lz_blank[idx] || blink_off;
    cur_dp          = shadow_dp[idx] && !blink_off;
  end

  seg7_decode u_decode (
    .digit    (cur_digit),
    .blank    (cur_blank),
    .dp       (cur_dp),
    .segments (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments   <= SEG_BLANK;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (!decode_en) begin
        segments  <= SEG_BLANK;
        digit_sel <= '0;
      end else begin
        digit_sel <= sel_onehot;
        segments  <= (presc < PW'(BLANK_CYC)) ? SEG_BLANK : dec_seg;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
// Output after posedge k reflects slot state k-1: digit ((k-1)/8)%4, offset (k-1)%8, frame (k-1)/32.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic        load = 1'b0;
  logic        decode_en = 1'b1;
  logic        lz_suppress = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [7:0]  segments;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS     (4),
    .SCAN_DIV     (8),
    .BLANK_CYC    (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_i    (digits_i),
    .dp_i        (dp_i),
    .load        (load),
    .decode_en   (decode_en),
    .lz_suppress (lz_suppress),
    .blink_mask  (blink_mask),
    .segments    (segments),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (k=%0d)", tag, obs, exp, k);
  endtask

  // Advance to the negedge following posedge number target.
  task automatic goto(input int target);
    if (target > k) begin
      while (k < target) begin
        @(posedge clk);
        k++;
      end
      @(negedge clk);
    end
  endtask

  task automatic seg_at(input string tag, input int target, input logic [7:0] exp);
    goto(target);
    check(tag, segments, exp);
  endtask

  task automatic sel_at(input string tag, input int target, input logic [3:0] exp);
    goto(target);
    check(tag, {4'b0000, digit_sel}, {4'b0000, exp});
  endtask

  task automatic fd_at(input string tag, input int target, input logic exp);
    goto(target);
    check(tag, {7'd0, frame_done}, {7'd0, exp});
  endtask

  task automatic load_at(input int target, input logic [15:0] d, input logic [3:0] dp);
    goto(target - 1);
    digits_i = d;
    dp_i     = dp;
    load     = 1'b1;
    goto(target);
    load     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_seg", segments, 8'h00);
    check("rst_sel", {4'b0000, digit_sel}, 8'h00);
    check("rst_fd", {7'd0, frame_done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    // Scan order and anti-ghost blanking, shadow starts at all zeros.
    sel_at("scan_d0", 1, 4'b0001);
    check("ghost_o0", segments, 8'h00);
    seg_at("ghost_o1", 2, 8'h00);
    seg_at("zero_d0", 3, 8'b1111_1100);
    sel_at("scan_d1", 9, 4'b0010);

    load_at(11, 16'h9870, 4'b0000);
    sel_at("scan_d2", 17, 4'b0100);
    sel_at("scan_d3", 25, 4'b1000);
    seg_at("hold_old_d3", 27, 8'b1111_1100);
    fd_at("fd_pre", 31, 1'b0);
    fd_at("fd_edge", 32, 1'b1);
    fd_at("fd_post", 33, 1'b0);
    sel_at("scan_wrap", 33, 4'b0001);

    // Frame 1 shows 9870.
    seg_at("dec_d0_0", 35, 8'b1111_1100);
    seg_at("ghost_d1_o0", 41, 8'h00);
    seg_at("ghost_d1_o1", 42, 8'h00);
    seg_at("dec_d1_7", 43, 8'b1110_0000);
    lz_suppress = 1'b1;
    load_at(44, 16'h0005, 4'b0100);
    seg_at("dec_d1_end", 48, 8'b1110_0000);
    seg_at("dec_d2_8", 51, 8'b1111_1110);
    seg_at("dec_d3_9", 59, 8'b1111_0110);
    fd_at("fd_frame1", 64, 1'b1);

    // Frame 2: 0005 with leading zeros suppressed, dp on digit 2.
    seg_at("lz_d0_5", 67, 8'b1011_0110);
    load_at(70, 16'h0000, 4'b0000);
    seg_at("lz_d1", 75, 8'h00);
    seg_at("lz_d2_dp", 83, 8'b0000_0001);
    seg_at("lz_d3", 91, 8'h00);

    // Frame 3: all zeros, digit 0 is never suppressed; 1234 loaded mid-frame.
    seg_at("lz_all0_d0", 99, 8'b1111_1100);
    load_at(100, 16'h1234, 4'b0000);
    seg_at("tear_d1_old", 107, 8'h00);
    seg_at("tear_d3_old", 123, 8'h00);

    // Frame 4: 1234.
    seg_at("new_d0_4", 131, 8'b0110_0110);
    seg_at("new_d1_3", 139, 8'b1111_0010);
    seg_at("new_d2_2", 147, 8'b1101_1010);
    seg_at("new_d3_1", 155, 8'b0110_0000);

    // Load on the boundary cycle itself lands in frame 5.
    load_at(160, 16'h5678, 4'b0000);
    check("fd_bnd_load", {7'd0, frame_done}, 8'h01);
    seg_at("bnd_d0_8", 163, 8'b1111_1110);
    seg_at("bnd_d3_5", 187, 8'b1011_0110);

    // Blink phase is 1 during frames 6-7, 0 during frames 8-9.
    blink_mask = 4'b0010;
    seg_at("blink_d0_lit", 195, 8'b1111_1110);
    sel_at("blink_sel_d1", 201, 4'b0010);
    seg_at("blink_d1_off", 203, 8'h00);
    seg_at("blink_d2_lit", 211, 8'b1011_1110);
    seg_at("blink_d1_off7", 235, 8'h00);
    seg_at("blink_d1_on8", 267, 8'b1110_0000);

    // decode_en low blanks outputs next cycle while the scan keeps running.
    goto(270);
    decode_en = 1'b0;
    seg_at("den_seg", 271, 8'h00);
    check("den_sel", {4'b0000, digit_sel}, 8'h00);
    fd_at("den_fd", 288, 1'b1);
    decode_en = 1'b1;
    sel_at("den_back_sel", 289, 4'b0001);
    check("den_back_ghost", segments, 8'h00);
    seg_at("den_back_d0", 291, 8'b1111_1110);

    // Asynchronous reset mid-slot.
    seg_at("pre_rst_d0", 293, 8'b1111_1110);
    rst_n = 1'b0;
    #1;
    check("arst_seg", segments, 8'h00);
    check("arst_sel", {4'b0000, digit_sel}, 8'h00);
    check("arst_fd", {7'd0, frame_done}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    sel_at("rst_scan_d0", 1, 4'b0001);
    seg_at("rst_shadow_d0", 3, 8'b1111_1100);
    sel_at("rst_scan_d1", 9, 4'b0010);
    seg_at("rst_lz_d1", 11, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
